// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button input path: button indices, 50 MHz default
// cycle counts and the auto-repeat state encoding.
package button_conditioner_pkg;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;
  localparam int BTN_D = 3;

  localparam int N_BTN_DEFAULT               = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT     = 500_000;     // 10 ms at 50 MHz
  localparam int REPEAT_DELAY_CYCLES_DEFAULT = 20_000_000;  // 400 ms at 50 MHz
  localparam int REPEAT_RATE_CYCLES_DEFAULT  = 5_000_000;   // 100 ms at 50 MHz

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-FF synchronizer, debounce filter, press/release pulses and the
// auto-repeat state machine.
module button_conditioner_channel
  import button_conditioner_pkg::*;
#(
  parameter int ACTIVE_LOW          = 1,
  parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEFAULT,
  parameter int REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam logic RAW_IDLE = (ACTIVE_LOW != 0);
  localparam int   CNT_W    = max_int(1, $clog2(DEBOUNCE_CYCLES + 1));
  localparam int   TIMER_W  = max_int(1, $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)));

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner_channel: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY_CYCLES < 2 || REPEAT_RATE_CYCLES < 2) begin : g_bad_repeat
    $error("button_conditioner_channel: REPEAT_*_CYCLES must be >= 2");
  end

  logic               sync_1, sync_2;
  logic               pressed_in;
  logic [CNT_W-1:0]   db_cnt;
  logic               accept, rise, fall;
  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;

  // NOTE: every clocked block uses non-blocking assignments so sync_2 samples the old sync_1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= RAW_IDLE;
      sync_2 <= RAW_IDLE;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  assign pressed_in = (ACTIVE_LOW != 0) ? ~sync_2 : sync_2;

  // A change is accepted once the synced input has disagreed with the level for
  // DEBOUNCE_CYCLES counted cycles plus the current one; any agreement restarts the count.
  assign accept = (pressed_in != btn_level) && (db_cnt == CNT_W'(DEBOUNCE_CYCLES));
  assign rise   = accept & pressed_in;
  assign fall   = accept & ~pressed_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= rise;
      btn_release <= fall;
      if (pressed_in == btn_level || accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
      if (accept) begin
        btn_level <= pressed_in;
      end
    end
  end

  // Release or a dropped enable always returns to IDLE silently, even on a timer expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      btn_repeat <= 1'b0;
    end else begin
      btn_repeat <= 1'b0;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (rise) begin
            btn_repeat <= 1'b1;
            if (repeat_en) state <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (fall || !repeat_en) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == TIMER_W'(REPEAT_DELAY_CYCLES - 1)) begin
            btn_repeat <= 1'b1;
            state      <= ST_REPEAT;
            timer      <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        ST_REPEAT: begin
          if (fall || !repeat_en) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (timer == TIMER_W'(REPEAT_RATE_CYCLES - 1)) begin
            btn_repeat <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Player-input front end: one independent conditioning channel per push button,
// turning raw asynchronous pins into clean clk-synchronous level/press/release/repeat events.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN               = N_BTN_DEFAULT,
  parameter int ACTIVE_LOW          = 1,
  parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEFAULT,
  parameter int REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_channel
    button_conditioner_channel #(
      .ACTIVE_LOW          (ACTIVE_LOW),
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .repeat_en   (repeat_en[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized pin
// activity, every cycle compared against a behavioural model of the button rules.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] repeat_en;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN               (NB),
    .ACTIVE_LOW          (1),
    .DEBOUNCE_CYCLES     (DB),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_RATE_CYCLES  (RR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  always #5 clk = ~clk;

  // Model: a pin sample reaches the filter two edges later; a change is accepted after
  // DB+1 consecutive disagreeing samples; repeats are timed arithmetically from the press.
  int            cyc = 0;
  int            first_cyc = 0;
  bit            hist   [NB][8];
  int            streak [NB];
  int            armed  [NB];
  logic [NB-1:0] e_level = '0, e_press = '0, e_release = '0, e_repeat = '0;

  task automatic model_edge();
    e_press   = '0;
    e_release = '0;
    e_repeat  = '0;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        streak[i] = 0;
        armed[i]  = -1;
      end
      e_level   = '0;
      first_cyc = cyc + 1;
    end else begin
      for (int i = 0; i < NB; i++) begin
        bit p, x;
        int k;
        p = ~btn_raw[i];
        hist[i][cyc % 8] = p;
        x = (cyc - 2 >= first_cyc) ? hist[i][(cyc - 2) % 8] : 1'b0;
        if (x != e_level[i]) streak[i]++;
        else streak[i] = 0;
        if (streak[i] == DB + 1) begin
          streak[i]    = 0;
          e_level[i]   = x;
          e_press[i]   = x;
          e_release[i] = ~x;
        end
        if (e_press[i]) begin
          e_repeat[i] = 1'b1;
          armed[i]    = repeat_en[i] ? cyc : -1;
        end else if (e_release[i] || !repeat_en[i]) begin
          armed[i] = -1;
        end else if (armed[i] >= 0) begin
          k = cyc - armed[i];
          if (k == RD || (k > RD && (k - RD) % RR == 0)) e_repeat[i] = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare();
    checks++;
    if (btn_level !== e_level) begin
      errors++;
      $display("FAIL level cyc=%0d got=%b exp=%b", cyc, btn_level, e_level);
    end
    checks++;
    if (btn_press !== e_press) begin
      errors++;
      $display("FAIL press cyc=%0d got=%b exp=%b", cyc, btn_press, e_press);
    end
    checks++;
    if (btn_release !== e_release) begin
      errors++;
      $display("FAIL release cyc=%0d got=%b exp=%b", cyc, btn_release, e_release);
    end
    checks++;
    if (btn_repeat !== e_repeat) begin
      errors++;
      $display("FAIL repeat cyc=%0d got=%b exp=%b", cyc, btn_repeat, e_repeat);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic test_reset();
    int spurious = 0;
    reset     = 1'b1;
    btn_raw   = '1;
    repeat_en = '0;
    repeat (3) step();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      step();
      if (|btn_press || |btn_repeat || |btn_level) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL reset_quiet got=%0d active cycles exp=0", spurious);
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int n = 0;
    int nrep = 0;
    btn_raw[BTN_A] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (btn_press[BTN_A]) begin
        n++;
        if (first < 0) first = k;
      end
      if (btn_repeat[BTN_A]) nrep++;
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL clean_latency got=%0d exp=6", first);
    end
    checks++;
    if (n !== 1 || nrep !== 1) begin
      errors++;
      $display("FAIL clean_pulses got press=%0d repeat=%0d exp 1/1", n, nrep);
    end
    btn_raw[BTN_A] = 1'b1;
    repeat (10) step();
    checks++;
    if (btn_level[BTN_A] !== 1'b0) begin
      errors++;
      $display("FAIL clean_release got=%b exp=0", btn_level[BTN_A]);
    end
  endtask

  task automatic test_bounce();
    int first = -1;
    int n = 0;
    btn_raw[BTN_B] = 1'b0;
    repeat (3) begin step(); if (btn_press[BTN_B]) n++; end
    btn_raw[BTN_B] = 1'b1;
    step();
    if (btn_press[BTN_B]) n++;
    btn_raw[BTN_B] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (btn_press[BTN_B]) begin
        n++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first !== 6 || n !== 1) begin
      errors++;
      $display("FAIL bounce got first=%0d count=%0d exp first=6 count=1", first, n);
    end
    btn_raw[BTN_B] = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_repeat_hold();
    int press_k = -1;
    int offs[$];
    int exp_offs[8] = '{0, 10, 13, 16, 19, 22, 25, 28};
    int nrel = 0;
    repeat_en[BTN_C] = 1'b1;
    btn_raw[BTN_C]   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (btn_press[BTN_C] && press_k < 0) press_k = k;
      if (press_k >= 0 && k - press_k < 30 && btn_repeat[BTN_C]) offs.push_back(k - press_k);
    end
    checks++;
    if (press_k !== 6 || offs.size() !== 8) begin
      errors++;
      $display("FAIL repeat_count got press=%0d pulses=%0d exp 6/8", press_k, offs.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (offs[j] !== exp_offs[j]) begin
          errors++;
          $display("FAIL repeat_offset[%0d] got=%0d exp=%0d", j, offs[j], exp_offs[j]);
        end
      end
    end
    btn_raw[BTN_C] = 1'b1;
    repeat (12) begin step(); if (btn_release[BTN_C]) nrel++; end
    checks++;
    if (nrel !== 1) begin
      errors++;
      $display("FAIL repeat_release got=%0d exp=1", nrel);
    end
  endtask

  task automatic test_single_repeat();
    int nrep = 0;
    int nrel = 0;
    repeat_en[BTN_D] = 1'b0;
    btn_raw[BTN_D]   = 1'b0;
    repeat (30) begin step(); if (btn_repeat[BTN_D]) nrep++; end
    btn_raw[BTN_D] = 1'b1;
    repeat (12) begin step(); if (btn_release[BTN_D]) nrel++; end
    checks++;
    if (nrep !== 1 || nrel !== 1 || btn_level[BTN_D] !== 1'b0) begin
      errors++;
      $display("FAIL single_repeat got repeat=%0d release=%0d level=%b exp 1/1/0",
               nrep, nrel, btn_level[BTN_D]);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int first = -1;
    repeat_en[BTN_C] = 1'b1;
    btn_raw[BTN_C]   = 1'b0;
    repeat (22) step();
    checks++;
    if (btn_level[BTN_C] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_held got=%b exp=1", btn_level[BTN_C]);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
      errors++;
      $display("FAIL midrst_clear got=%h exp=0", {btn_level, btn_press, btn_release, btn_repeat});
    end
    repeat (3) step();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (btn_press[BTN_C] && btn_repeat[BTN_C] && first < 0) first = k;
    end
    checks++;
    if (first !== 6) begin
      errors++;
      $display("FAIL midrst_repress got=%0d exp=6", first);
    end
    btn_raw[BTN_C] = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_random();
    int hold[NB];
    for (int i = 0; i < NB; i++) hold[i] = 0;
    repeat_en = '1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = 1'($urandom_range(0, 1));
          hold[i]    = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 5);
        end else begin
          hold[i]--;
        end
        if ($urandom_range(0, 29) == 0) repeat_en[i] = ~repeat_en[i];
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat_hold();
    test_single_repeat();
    test_reset_mid_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
